// File: rtl/dct8x8_fwd_core.sv
// -----------------------------------------------------------------------------
// dct8x8_fwd_core
//   Forward 8x8 orthonormal DCT-II using row-column decomposition. One 8x8
//   block is loaded serially in raster order, transformed row-wise and then
//   column-wise through one shared bank of 8 multipliers feeding an adder tree.
//   The 64 coefficients are then streamed out in row-major order (v*8+u).
//   The block period is 256 cycles: LOAD, ROW, COL and OUT take 64 cycles each.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high; aborts any block in progress
//   start      level request; sampled in IDLE and on the last OUT cycle
//   din        signed input pixel, sampled on every edge where reading=1
//   reading    high during the 64 LOAD cycles
//   done       high for the 64 cycles during which dout is valid
//   dout       signed Q(WIDTH-OUT_FRAC).OUT_FRAC coefficient, registered
//   state_out  FSM state code (IDLE=0, LOAD=1, ROW=2, COL=3, OUT=4)
// -----------------------------------------------------------------------------
module dct8x8_fwd_core #(
  parameter int WIDTH     = 32,
  parameter int COEF_FRAC = 12,
  parameter int OUT_FRAC  = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             reading,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [4:0]       state_out
);

  // The row pass drops enough fraction bits that the column pass, which adds
  // another COEF_FRAC fraction bits, lands exactly on OUT_FRAC.
  localparam int ROW_SHIFT = 2 * COEF_FRAC - OUT_FRAC;
  // Row results: the widest row sum after the shift, with headroom.
  localparam int RW        = WIDTH + 16;
  // Product of an RW operand and a 14-bit coefficient, plus 3 bits for 8 terms.
  localparam int ACC_W     = RW + 14 + 3;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [4:0] {
    S_IDLE = 5'd0,
    S_LOAD = 5'd1,
    S_ROW  = 5'd2,
    S_COL  = 5'd3,
    S_OUT  = 5'd4
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] cnt;

  logic signed [WIDTH-1:0] x_mem [64];  // pixels, index i*8+n
  logic signed [RW-1:0]    r_mem [64];  // row transform, index i*8+u
  logic signed [WIDTH-1:0] y_mem [64];  // coefficients, index v*8+u

  logic signed [ACC_W-1:0] acc;
  logic signed [RW-1:0]    opnd;
  logic [2:0]              coef_sel;
  logic signed [RW-1:0]    r_next;
  logic signed [WIDTH-1:0] y_sat;

  // Cosine ROM scaled by 2^12: C[k][n] = round(4096 * c(k)/2 * cos((2n+1)k*pi/16)).
  // The angle index (2n+1)*k is reduced mod 32 (one full turn) and folded
  // into the first quadrant; the 5-bit product wraps mod 32 by itself.
  function automatic logic signed [13:0] cos_coef(input logic [2:0] k,
                                                  input logic [2:0] n);
    logic [4:0]           idx;
    logic [4:0]           m;
    logic                 neg;
    logic signed [13:0]   mag;
    idx = {1'b0, n, 1'b1} * {2'b00, k};
    if (idx <= 5'd8) begin
      m = idx;          neg = 1'b0;
    end else if (idx <= 5'd16) begin
      m = 5'd16 - idx;  neg = 1'b1;
    end else if (idx <= 5'd24) begin
      m = idx - 5'd16;  neg = 1'b1;
    end else begin
      m = 5'd0 - idx;   neg = 1'b0;  // 32 - idx
    end
    case (m)
      5'd0:    mag = 14'sd2048;
      5'd1:    mag = 14'sd2009;
      5'd2:    mag = 14'sd1892;
      5'd3:    mag = 14'sd1703;
      5'd4:    mag = 14'sd1448;
      5'd5:    mag = 14'sd1138;
      5'd6:    mag = 14'sd784;
      5'd7:    mag = 14'sd400;
      default: mag = 14'sd0;
    endcase
    if (k == 3'd0) return 14'sd1448;  // c(0)/2 = 1/(2*sqrt(2))
    return neg ? -mag : mag;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Each busy phase is exactly 64 cycles, so the counter simply wraps.
      cnt   <= (state == S_IDLE) ? 6'd0 : cnt + 6'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    reading   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        reading = 1'b1;
        if (cnt == 6'd63) state_nxt = S_ROW;
      end
      S_ROW:  if (cnt == 6'd63) state_nxt = S_COL;
      S_COL:  if (cnt == 6'd63) state_nxt = S_OUT;
      S_OUT:  if (cnt == 6'd63) state_nxt = start ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_out = state;

  // ---------------------------------------------------------------------------
  // Shared datapath: 8 multipliers and an adder tree.
  //   ROW: cnt = {i,u}; acc = sum_n x[i][n] * C[u][n]
  //   COL: cnt = {v,u}; acc = sum_i R[i][u] * C[v][i]
  // ---------------------------------------------------------------------------
  always_comb begin
    acc      = '0;
    opnd     = '0;
    coef_sel = (state == S_COL) ? cnt[5:3] : cnt[2:0];
    for (int j = 0; j < 8; j++) begin
      if (state == S_COL) opnd = r_mem[{3'(j), cnt[2:0]}];
      else                opnd = RW'(x_mem[{cnt[5:3], 3'(j)}]);
      acc = acc + ACC_W'(opnd) * ACC_W'(cos_coef(coef_sel, 3'(j)));
    end
  end

  // Arithmetic shift: truncates toward minus infinity.
  assign r_next = RW'(acc >>> ROW_SHIFT);

  always_comb begin
    if (acc > Y_MAX)      y_sat = WIDTH'(Y_MAX);
    else if (acc < Y_MIN) y_sat = WIDTH'(Y_MIN);
    else                  y_sat = WIDTH'(acc);
  end

  // NOTE: the block buffers are deliberately not reset; every entry is
  // rewritten before it is read, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) x_mem[cnt] <= din;
    if (state == S_ROW)  r_mem[cnt] <= r_next;
    if (state == S_COL)  y_mem[cnt] <= y_sat;
  end

  // ---------------------------------------------------------------------------
  // Output register: loads DC on the last COL edge, so done and dout rise on
  // the same edge the FSM enters OUT; both return to 0 when OUT ends.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      dout <= '0;
    end else if (state == S_COL && cnt == 6'd63) begin
      done <= 1'b1;
      dout <= y_mem[0];
    end else if (state == S_OUT && cnt != 6'd63) begin
      done <= 1'b1;
      dout <= y_mem[cnt + 6'd1];
    end else begin
      done <= 1'b0;
      dout <= '0;
    end
  end

endmodule

// File: tb/tb_dct8x8_fwd_core.sv
// -----------------------------------------------------------------------------
// tb_dct8x8_fwd_core
//   Directed bench for dct8x8_fwd_core. Expected coefficients come from a
//   real-valued DCT using the 12-bit cosine table built here from its
//   definition; they are queued when a block is fed and popped as done
//   streams. A few coefficients are also checked against the exact DCT.
// -----------------------------------------------------------------------------
module tb_dct8x8_fwd_core;

  localparam int  WIDTH    = 32;
  localparam int  OUT_FRAC = 18;
  localparam longint TOL   = 64'd65536;  // 2^-2 in Q.18

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] din;
  logic        reading;
  logic        done;
  logic [31:0] dout;
  logic [4:0]  state_out;

  dct8x8_fwd_core #(.WIDTH(WIDTH), .COEF_FRAC(12), .OUT_FRAC(OUT_FRAC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .reading   (reading),
    .done      (done),
    .dout      (dout),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_vec = 0;
  int     n_bad = 0;
  longint exp_q[$];
  longint got [64];
  int     rom [8][8];
  int     blk [64];
  int     load_cyc;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint expv);
    longint diff;
    diff = obs - expv;
    if (diff < 0) diff = -diff;
    n_vec++;
    assert (diff <= TOL) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, expv, TOL);
    end
  endtask

  task automatic build_rom();
    real ck;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      for (int n = 0; n < 8; n++)
        rom[k][n] = int'(4096.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0));
    end
  endtask

  // Y[v][u] = sum_i sum_n C[v][i] C[u][n] x[i][n] / 2^24, scaled to Q.18.
  task automatic push_model(input int px [64]);
    longint s;
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) begin
        s = 0;
        for (int i = 0; i < 8; i++)
          for (int n = 0; n < 8; n++)
            s += longint'(rom[v][i]) * rom[u][n] * px[i * 8 + n];
        exp_q.push_back(longint'(real'(s) / 64.0));
      end
  endtask

  // Feed one block, walk through ROW/COL, then score the 64-cycle done burst.
  // start is dropped at wait cycle drop_at (0..63 ROW, 64..127 COL), if >= 0.
  task automatic run_block(input string tag, input int px [64], input int drop_at);
    int     waited;
    int     rd_cnt;
    int     early;
    int     dn_cnt;
    longint expv;
    push_model(px);
    waited = 0;
    @(negedge clk);
    while (!reading && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_load_entry"}, longint'(reading), 1);
    check({tag, "_state_load"}, longint'(state_out), 1);
    load_cyc = cyc;
    rd_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (reading) rd_cnt++;
      din = px[k];
    end
    check({tag, "_reading_len"}, longint'(rd_cnt), 64);
    early = 0;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      din = 32'hDEAD_BEEF;  // must be ignored outside LOAD
      if (j == 0)  check({tag, "_state_row"}, longint'(state_out), 2);
      if (j == 64) check({tag, "_state_col"}, longint'(state_out), 3);
      if (j == drop_at) start = 1'b0;
      if (done || reading) early++;
    end
    check({tag, "_quiet_row_col"}, longint'(early), 0);
    dn_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, "_state_out"}, longint'(state_out), 4);
      if (done) dn_cnt++;
      got[k] = longint'($signed(dout));
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd0;
      check_near($sformatf("%s_coef%0d", tag, k), got[k], expv);
    end
    check({tag, "_done_len"}, longint'(dn_cnt), 64);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_state"}, longint'(state_out), 0);
    check({tag, "_idle_done"},  longint'(done), 0);
    check({tag, "_idle_dout"},  longint'(dout), 0);
    check({tag, "_idle_read"},  longint'(reading), 0);
  endtask

  task automatic rand_block();
    for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 255));
  endtask

  initial begin
    int t_prev;
    int ac_ok;
    int waited;
    int stray;
    build_rom();
    reset = 1'b1;
    start = 1'b0;
    din   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state",   longint'(state_out), 0);
    check("rst_reading", longint'(reading), 0);
    check("rst_done",    longint'(done), 0);
    check("rst_dout",    longint'(dout), 0);
    reset = 1'b0;

    // All-zero block
    for (int k = 0; k < 64; k++) blk[k] = 0;
    start = 1'b1;
    run_block("zero", blk, 10);
    for (int k = 0; k < 64; k++) check($sformatf("zero_exact%0d", k), got[k], 0);
    check_idle("zero");

    // Constant block: DC is 800, every AC integer part is -1 or 0
    for (int k = 0; k < 64; k++) blk[k] = 100;
    start = 1'b1;
    run_block("const", blk, 10);
    check_near("const_dc_exact", got[0], 64'd800 << OUT_FRAC);
    ac_ok = 1;
    for (int k = 1; k < 64; k++)
      if ((got[k] >>> OUT_FRAC) != 0 && (got[k] >>> OUT_FRAC) != -1) ac_ok = 0;
    check("const_ac_int", longint'(ac_ok), 1);
    check_idle("const");

    // Impulse at index 0: DC = 255/8 = 31.875
    for (int k = 0; k < 64; k++) blk[k] = 0;
    blk[0] = 255;
    start = 1'b1;
    run_block("imp", blk, 10);
    check_near("imp_dc_exact", got[0], longint'(31.875 * 262144.0));
    check("imp_dc_int", got[0] >>> OUT_FRAC, 31);
    // Y[0][1] = 255 * (1/sqrt(2)) * cos(pi/16) / 4
    check_near("imp_01_exact", got[1], longint'(255.0 * 0.98078528 / (4.0 * 1.41421356) * 262144.0));
    check_idle("imp");

    // Three back-to-back random blocks with start held high
    start = 1'b1;
    rand_block();
    run_block("b2b0", blk, -1);
    t_prev = load_cyc;
    rand_block();
    run_block("b2b1", blk, -1);
    check("b2b_period1", longint'(load_cyc - t_prev), 256);
    t_prev = load_cyc;
    rand_block();
    run_block("b2b2", blk, 10);
    check("b2b_period2", longint'(load_cyc - t_prev), 256);
    check_idle("b2b");

    // Reset during LOAD aborts; the next block is unaffected
    start = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!reading && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("abort_entry", longint'(reading), 1);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      din = 32'd255;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_reading", longint'(reading), 0);
    check("abort_state",   longint'(state_out), 0);
    reset = 1'b0;

    // Fresh block; start drops during COL and the block still completes
    rand_block();
    run_block("post", blk, 80);
    check_idle("post");
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (reading || done || state_out != 5'd0) stray++;
    end
    check("post_stays_idle", longint'(stray), 0);
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dct8x8_fwd_core.md
Name: dct8x8_fwd_core

Overview:
- Forward 8x8 two-dimensional DCT engine (orthonormal DCT-II) using row-column decomposition.
- Accepts one 8x8 pixel block serially, one sample per clock, and streams out 64 fixed-point coefficients.
- Sits ahead of the matching IDCT block; the done/dout stream drives the IDCT's start/din directly.

Parameters:
- WIDTH, 32, data width of din/dout.
- COEF_FRAC, 12, fractional bits of the cosine coefficient ROM.
- OUT_FRAC, 18, fractional bits of dout. dout[31:18] is the signed integer coefficient.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request to process blocks; sampled in IDLE and at the end of OUT.
- din  in  WIDTH  input pixel, signed two's complement, row-major raster within the block; 8-bit pixels are zero-extended by the source.
- reading  out  1  high while the block is consuming din; din is sampled on every rising edge where reading=1.
- done  out  1  high for exactly 64 consecutive cycles while dout carries valid coefficients.
- dout  out  WIDTH  coefficient, signed Q(WIDTH-OUT_FRAC).OUT_FRAC.
- state_out  out  5  current FSM state code, for debug.

Behaviour:
- Reset, when high at a clock edge:
  - state = IDLE; reading=0, done=0, dout=0, state_out=0.
  - Counters are cleared and any block in progress is aborted and discarded.
  - Reset has priority over start.
- FSM state codes: IDLE=0, LOAD=1, ROW=2, COL=3, OUT=4.
- IDLE: wait. When start=1 at an edge, go to LOAD.
- LOAD:
  - reading=1 for exactly 64 cycles.
  - Sample k (k=0..63) is stored as x[k/8][k%8].
  - After the 64th sample, go to ROW.
- ROW: 64 cycles. Each cycle computes one R[i][u] = (sum over n of x[i][n]*C[u][n]) >>> 6. The result is Q.6, stored in the transpose buffer.
- COL: 64 cycles. Each cycle computes one Y[u][v] = sum over i of R[i][v]... applied along columns, i.e. Y[v][u] = sum over i of C[v][i]*R[i][u]. The result is Q.18, stored in the output buffer.
- Coefficient ROM: C[k][n] = round(2^12 * c(k)/2 * cos((2n+1)k*pi/16)), with c(0)=1/sqrt(2) and c(k>0)=1. Values are signed 14-bit.
- Datapath:
  - 8 parallel multipliers plus an adder tree per pass.
  - Accumulators are at least 40 bits, signed; shifts are arithmetic, truncating toward minus infinity.
  - dout saturates to the signed WIDTH range (does not occur for 8-bit pixels).
- OUT:
  - done=1 for 64 cycles.
  - dout presents Y in row-major order: index = v*8+u, v = vertical frequency, u = horizontal frequency.
  - The first cycle carries DC.
  - dout is registered; done and dout change on the same edge.
- End of OUT: if start=1, go to LOAD (back-to-back blocks); otherwise go to IDLE.
- Timing:
  - Latency from the first reading cycle to the first done cycle is 192 cycles.
  - Block period is 256 cycles; min idle gap between blocks is 0.
- Outside OUT: done=0 and dout holds 0. Outside LOAD: reading=0.
- start deasserting mid-block does not abort; the current block completes fully.
- Scaling: dout/2^18 ≈ orthonormal DCT-II of the block. DC = sum/8.
- Accuracy: each coefficient is within ±2^-2 (2^16 LSB) of the exact real-valued DCT.

Test Plan:
- Reset then start=1; all din=0 -> reading high for 64 cycles, then done high for 64 cycles with dout=0 throughout; state_out sequence 0,1,2,3,4.
- Constant block din=100 -> first done cycle dout[31:18]=800; remaining 63 coefficients with dout[31:18] in {-1,0}.
- Impulse: din=255 at index 0, others 0 -> DC dout ≈ 31.875*2^18 (dout[31:18]=31); coefficient (0,1) ≈ 255*0.1734*... matches the reference model within ±2^16 LSB.
- Three back-to-back random 8-bit blocks with start held high -> reading windows 256 cycles apart; each done burst matches the model within tolerance; no idle gaps.
- Reset asserted at cycle 30 of LOAD -> next edge reading=0, state_out=0; a subsequent block processes correctly with no residue from the aborted data.
- start dropped during COL -> the current block still outputs 64 coefficients, then the FSM returns to IDLE with reading staying 0.
